tuser_out_unit: RTL and testbench

Output-side metadata merger for the packet pipeline: binds one 128-bit tuple (from the tuple/match engine) to one AXI4-Stream packet and emits the packet with that tuple on TUSER. It sits between the packet datapath and the egress AXIS interface. Packets are gated until their tuple has arrived. Every beat is re-timed through a single output register, which keeps full throughput.

---
 rtl/tuser_out_unit.sv | 135 +++++++++++++
 tb/tb_tuser_out_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tuser_out_unit.sv
// rtl/tuser_out_unit.sv - binds a 128-bit tuple to each AXIS packet on TUSER; `TUSER_OUT_DBG_EN exposes FSM state on dbg_state
module tuser_out_unit (
    input  logic         tout_aclk,
    input  logic         tout_arst,
    input  logic         tout_avalid,
    output logic         tout_aready,
    input  logic [255:0] tout_adata,
    input  logic [31:0]  tout_akeep,
    input  logic         tout_atlast,
    input  logic         tout_valid,
    input  logic [127:0] tout_data,
    output logic         tout_bvalid,
    input  logic         tout_bready,
    output logic [255:0] tout_bdata,
    output logic [31:0]  tout_bkeep,
    output logic         tout_btlast,
    output logic [127:0] tout_btuser,
    output logic [0:2]   dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_BODY  = 3'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   cur_q, cur_d;
    logic [127:0]   pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;

    logic           bvalid_q;
    logic [255:0]   bdata_q;
    logic [31:0]    bkeep_q;
    logic           btlast_q;
    logic [127:0]   btuser_q;

    logic           aready;
    logic           accept;
    logic           pkt_end;

    // Accept a beat only with a tuple held and room in the output register
    always_comb begin
        aready  = (state_q != ST_IDLE) && (!bvalid_q || tout_bready);
        accept  = tout_avalid && aready;
        pkt_end = accept && tout_atlast;
    end

    // Next-state and tuple bookkeeping; a queued tuple takes priority over a same-cycle one
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        case (state_q)
            ST_IDLE: begin
                if (tout_valid) begin
                    cur_d   = tout_data;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST, ST_BODY: begin
                if (pkt_end) begin
                    if (pend_vld_q) begin
                        cur_d      = pend_q;
                        pend_vld_d = 1'b0;
                        state_d    = ST_FIRST;
                    end else if (tout_valid) begin
                        cur_d   = tout_data;
                        state_d = ST_FIRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (accept) begin
                        state_d = ST_BODY;
                    end
                    if (tout_valid && !pend_vld_q) begin
                        pend_d     = tout_data;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and tuple registers
    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Output skid-free register: load on accept, drop valid once consumed
    always_ff @(posedge tout_aclk or posedge tout_arst) begin
        if (tout_arst) begin
            bvalid_q <= 1'b0;
            bdata_q  <= '0;
            bkeep_q  <= '0;
            btlast_q <= 1'b0;
            btuser_q <= '0;
        end else if (accept) begin
            bvalid_q <= 1'b1;
            bdata_q  <= tout_adata;
            bkeep_q  <= tout_akeep;
            btlast_q <= tout_atlast;
            btuser_q <= cur_q;
        end else if (tout_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    assign tout_aready = aready;
    assign tout_bvalid = bvalid_q;
    assign tout_bdata  = bdata_q;
    assign tout_bkeep  = bkeep_q;
    assign tout_btlast = btlast_q;
    assign tout_btuser = btuser_q;

`ifdef TUSER_OUT_DBG_EN
    assign dbg_state = state_q;
`else
    assign dbg_state = 3'd0;
`endif

endmodule

// File: tb/tb_tuser_out_unit.sv
// tb/tb_tuser_out_unit.sv - scoreboard and table-driven bench for tuser_out_unit
module tb_tuser_out_unit;

    logic         clk;
    logic         rst;
    logic         avalid;
    logic         aready;
    logic [255:0] adata;
    logic [31:0]  akeep;
    logic         atlast;
    logic         tvalid;
    logic [127:0] tdata;
    logic         bvalid;
    logic         bready;
    logic [255:0] bdata;
    logic [31:0]  bkeep;
    logic         btlast;
    logic [127:0] btuser;
    logic [0:2]   dbg;

    tuser_out_unit dut (
        .tout_aclk   (clk),
        .tout_arst   (rst),
        .tout_avalid (avalid),
        .tout_aready (aready),
        .tout_adata  (adata),
        .tout_akeep  (akeep),
        .tout_atlast (atlast),
        .tout_valid  (tvalid),
        .tout_data   (tdata),
        .tout_bvalid (bvalid),
        .tout_bready (bready),
        .tout_bdata  (bdata),
        .tout_bkeep  (bkeep),
        .tout_btlast (btlast),
        .tout_btuser (btuser),
        .dbg_state   (dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
        logic [127:0] u;
    } beat_t;

    typedef struct {
        logic [127:0] tuple;
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] exp_tuser;
    } vec_t;

    beat_t sb[$];
    vec_t  tab[10];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_out    = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_state(input logic [2:0] exp);
`ifdef TUSER_OUT_DBG_EN
        chk("dbg_state", {253'd0, dbg}, {253'd0, exp});
`else
        chk("dbg_state_tied", {253'd0, dbg}, 256'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tuple(input logic [127:0] t);
        tvalid = 1'b1;
        tdata  = t;
        tick();
        tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                             input logic [127:0] exp_t, input logic tv, input logic [127:0] td);
        logic ok;
        beat_t b;
        ok     = 1'b0;
        avalid = 1'b1;
        adata  = d;
        akeep  = k;
        atlast = l;
        tvalid = tv;
        tdata  = td;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (aready) begin
                b.d = d; b.k = k; b.l = l; b.u = exp_t;
                sb.push_back(b);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            tvalid = 1'b0;
        end
        avalid = 1'b0;
        atlast = 1'b0;
        chk("beat_accept_timeout", {255'd0, ok}, 256'd1);
    endtask

    // Output monitor: scoreboard pop on handshake, stability under backpressure
    initial begin
        logic         hold_v;
        logic [255:0] hold_d;
        logic [127:0] hold_u;
        beat_t        e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_u = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("bp_hold_bvalid", {255'd0, bvalid}, 256'd1);
                    chk("bp_hold_bdata", bdata, hold_d);
                    chk("bp_hold_btuser", {128'd0, btuser}, {128'd0, hold_u});
                end
                if (bvalid && !bready) begin
                    hold_v = 1'b1;
                    hold_d = bdata;
                    hold_u = btuser;
                    chk("bp_aready_low", {255'd0, aready}, 256'd0);
                end else begin
                    hold_v = 1'b0;
                end
                if (bvalid && bready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 256'd1, 256'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("bdata", bdata, e.d);
                        chk("bkeep", {224'd0, bkeep}, {224'd0, e.k});
                        chk("btlast", {255'd0, btlast}, {255'd0, e.l});
                        chk("btuser", {128'd0, btuser}, {128'd0, e.u});
                    end
                end
            end
        end
    end

    initial begin
        int out_base;
        for (int i = 0; i < 10; i++) begin
            tab[i].tuple     = 128'hA000_0000 + 128'(i * 17 + 3);
            tab[i].data      = {8{32'hD000_0000 + 32'(i)}};
            tab[i].keep      = 32'hFFFF_FFFF >> i;
            tab[i].exp_tuser = 128'hA000_0000 + 128'(i * 17 + 3);
        end

        rst = 1'b1; avalid = 1'b0; adata = '0; akeep = '0; atlast = 1'b0;
        tvalid = 1'b0; tdata = '0; bready = 1'b1;

        // Reset
        repeat (2) tick();
        chk("rst_aready", {255'd0, aready}, 256'd0);
        chk("rst_bvalid", {255'd0, bvalid}, 256'd0);
        chk("rst_btlast", {255'd0, btlast}, 256'd0);
        chk("rst_bdata", bdata, 256'd0);
        chk("rst_bkeep", {224'd0, bkeep}, 256'd0);
        chk("rst_btuser", {128'd0, btuser}, 256'd0);
        chk_state(3'd0);
        rst = 1'b0;
        tick();

        // Stall in IDLE without a tuple
        avalid = 1'b1;
        adata  = 256'hDEAD;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_aready", {255'd0, aready}, 256'd0);
            chk("idle_bvalid", {255'd0, bvalid}, 256'd0);
            tick();
        end
        avalid = 1'b0;

        // Basic two-beat packet
        send_tuple(128'd44444);
        chk("tuple_latency_aready", {255'd0, aready}, 256'd1);
        chk_state(3'd1);
        send_beat(256'd22222, 32'd33333, 1'b0, 128'd44444, 1'b0, 128'd0);
        chk_state(3'd2);
        send_beat(256'd22222, 32'd33333, 1'b1, 128'd44444, 1'b0, 128'd0);
        chk_state(3'd0);
        chk("idle_after_pkt_aready", {255'd0, aready}, 256'd0);
        repeat (2) tick();

        // Backpressure on the first output beat
        bready = 1'b0;
        send_tuple(128'd5);
        send_beat(256'h0B01, 32'h1, 1'b0, 128'd5, 1'b0, 128'd0);
        fork
            send_beat(256'h0B02, 32'h3, 1'b1, 128'd5, 1'b0, 128'd0);
            begin
                repeat (4) tick();
                bready = 1'b1;
            end
        join
        repeat (2) tick();
        chk("bp_sb_drained", 256'(sb.size()), 256'd0);

        // Pending tuple: B queued mid-packet A, C dropped
        send_tuple(128'd1);
        send_beat(256'h0A1, 32'h7, 1'b0, 128'd1, 1'b0, 128'd0);
        send_tuple(128'd2);
        send_tuple(128'd3);
        send_beat(256'h0A2, 32'hF, 1'b1, 128'd1, 1'b0, 128'd0);
        chk("pend_no_idle_aready", {255'd0, aready}, 256'd1);
        chk_state(3'd1);
        send_beat(256'h0B1, 32'h1F, 1'b1, 128'd2, 1'b0, 128'd0);
        chk_state(3'd0);
        chk("pend_c_dropped_aready", {255'd0, aready}, 256'd0);
        repeat (2) tick();

        // Back-to-back single-beat packets, next tuple arriving with each last beat
        out_base = n_out;
        send_tuple(tab[0].tuple);
        for (int i = 0; i < 10; i++) begin
            if (i < 9)
                send_beat(tab[i].data, tab[i].keep, 1'b1, tab[i].exp_tuser, 1'b1, tab[i + 1].tuple);
            else
                send_beat(tab[i].data, tab[i].keep, 1'b1, tab[i].exp_tuser, 1'b0, 128'd0);
        end
        repeat (3) tick();
        chk("loop_out_count", 256'(n_out - out_base), 256'd10);
        chk("final_sb_empty", 256'(sb.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
